mc_control_unit: RTL
====================

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 32; width of retired-instruction counter.
REQ-002 SHALL have parameter WAIT_MAX, default 15; max memory wait cycles before trap; 0 disables timeout.
REQ-003 SHALL have port clk  input  1  sole clock; reset is synchronous and active-high.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports op[6:0], funct3[2:0], funct7_5, funct7_0, zero (inputs); funct7_0 is used only under MULDIV_EN.
REQ-006 SHALL have port mem_ready  input  1  memory access completes this cycle.
REQ-007 SHALL have outputs pc_write, adr_src, mem_write, ir_write, reg_write (1 each), alu_src_a[1:0], alu_src_b[1:0], result_src[1:0], imm_src[1:0], alu_control[2:0].
REQ-008 SHALL have outputs instret[CNT_W-1:0], trap (1), trap_cause[1:0] (0 illegal op, 1 memory timeout).
REQ-009 SHALL have output md_start (1) and input md_done (1) for the external multiply/divide unit.

Function
REQ-010 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, MDWAIT, TRAP.
REQ-011 FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10; ir_write and PC increment asserted only in the cycle mem_ready=1, which also moves to DECODE.
REQ-012 DECODE: alu_src_a=01, alu_src_b=01; next state by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, other->TRAP with cause 0.
REQ-013 MEMADR: alu_src_a=10, alu_src_b=01; load->MEMREAD, store->MEMWRITE.
REQ-014 MEMREAD holds adr_src=1 until mem_ready, then MEMWB; MEMWB: result_src=01, reg_write=1, ->FETCH.
REQ-015 MEMWRITE holds adr_src=1, mem_write=1 until mem_ready, then ->FETCH.
REQ-016 EXECR/EXECI: alu_src_a=10, alu_src_b=00/01, alu_control from funct3/funct7_5 (R-type: funct7_5 selects SUB; I-type: ADD unless funct3 selects other op); ->ALUWB; ALUWB: result_src=00, reg_write=1, ->FETCH.
REQ-017 BRANCH: alu_src_a=10, alu_src_b=00, alu_control=SUB; pc_write = zero XOR funct3[0] (beq/bne); ->FETCH.
REQ-018 JAL: alu_src_a=01, alu_src_b=10, result_src=00, reg_write=1, pc_write=1; ->ALUWB path not used, ->FETCH after one cycle.
REQ-019 imm_src SHALL be combinational from op: I=00, S=01, B=10, J=11; don't-care ops give 00.
REQ-020 pc_write in FETCH SHALL equal mem_ready; all unlisted outputs SHALL be 0 in each state.
REQ-021 Wait counter SHALL clear on entering FETCH/MEMREAD/MEMWRITE, increment each cycle mem_ready=0; reaching WAIT_MAX (nonzero) SHALL go to TRAP with cause 1 same cycle; mem_ready on that same cycle wins.
REQ-022 instret SHALL increment by 1 on every transition into FETCH from a non-FETCH state, wrapping modulo 2^CNT_W.
REQ-023 TRAP SHALL be absorbing until reset; trap=1, all write enables 0, instret frozen.

Reset
REQ-024 On rst=1 at a clk edge: state=FETCH, instret=0, wait counter=0, trap=0, trap_cause=0; all enables deasserted in the following cycle; rst mid-access SHALL abandon it with no write.

Configuration
REQ-025 With MULDIV_EN defined: EXECR with funct7_0=1 SHALL go to MDWAIT, pulse md_start for one cycle on entry, hold until md_done, then ->ALUWB with result_src=11.
REQ-026 Without MULDIV_EN: MDWAIT absent, md_start tied 0, md_done and funct7_0 ignored; funct7_0=1 R-type treated as base R-type.

Structure
REQ-027 State encoding, alu_control codes, imm_src codes, opcode constants SHALL reside in shared package mc_ctrl_pkg.
REQ-028 alu_control generation SHALL be one sub-module, alu_ctrl_dec.

Verification
REQ-029 add x3,x1,x2, mem_ready=1 in fetch -> states FETCH,DECODE,EXECR,ALUWB; reg_write=1 in cycle 4; instret 0->1.
REQ-030 lw with mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB reg_write=1, result_src=01.
REQ-031 bne, zero=0 -> BRANCH pc_write=1; beq, zero=0 -> pc_write=0.
REQ-032 op=0000000 -> TRAP, trap=1, cause=0, no further writes; WAIT_MAX=15, mem_ready stuck 0 in FETCH -> trap, cause=1 after 15 cycles.
REQ-033 rst asserted during MEMWRITE wait -> mem_write=0 next cycle, state FETCH, instret=0.
REQ-034 MULDIV_EN: mul, md_done after 5 cycles -> md_start one cycle, MDWAIT 5 cycles, ALUWB result_src=11.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle RISC-V control unit: state codes,
// ALU operation codes, immediate-format selects and opcodes.
package mc_ctrl_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_MDWAIT   = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd1;

    function automatic logic [1:0] imm_sel(input logic [6:0] opc);
        case (opc)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU operation decoder: maps funct3/funct7_5 to an ALU control code.
module alu_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       is_rtype,
    output logic [2:0] alu_control
);

    // funct7_5 on an I-type is an immediate bit, so only R-type may subtract
    always_comb begin
        alu_control = ALU_ADD;
        case (funct3)
            3'b000: alu_control = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_control = ALU_SLL;
            3'b010: alu_control = ALU_SLT;
            3'b011: alu_control = ALU_SLT;
            3'b100: alu_control = ALU_XOR;
            3'b101: alu_control = ALU_SRL;
            3'b110: alu_control = ALU_OR;
            3'b111: alu_control = ALU_AND;
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RISC-V control FSM with memory-wait timeout, trap and instret.
// Define MULDIV_EN to route funct7_0 R-types through an external mul/div unit.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             funct7_0,
    input  logic             zero,
    input  logic             mem_ready,
    input  logic             md_done,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic [1:0]       imm_src,
    output logic [2:0]       alu_control,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic             md_start
);

    localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [WW-1:0]    r_wait;
    logic [1:0]       r_cause;
    logic [1:0]       w_cause;
    logic [CNT_W-1:0] r_instret;
    logic             w_waiting;
    logic             w_timeout;
    logic [2:0]       w_alu_dec;
    logic             w_md_wb;

    alu_ctrl_dec u_alu_dec (
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .is_rtype    (r_state == S_EXECR),
        .alu_control (w_alu_dec)
    );

    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEMREAD)
                    || (r_state == S_MEMWRITE);
    // mem_ready in the final allowed cycle still completes the access
    assign w_timeout = (WAIT_MAX != 0) && w_waiting && !mem_ready
                    && (r_wait == WAIT_LAST);

    always_comb begin
        w_next  = r_state;
        w_cause = r_cause;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    default: begin
                        w_next  = S_TRAP;
                        w_cause = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR:   w_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
`ifdef MULDIV_EN
            S_EXECR:    w_next = funct7_0 ? S_MDWAIT : S_ALUWB;
            S_MDWAIT:   if (md_done) w_next = S_ALUWB;
`else
            S_EXECR:    w_next = S_ALUWB;
`endif
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JAL:      w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
        if (w_timeout) begin
            w_next  = S_TRAP;
            w_cause = CAUSE_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_cause   <= CAUSE_ILLEGAL;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause;
            if (w_next != r_state)
                r_wait <= '0;
            else if (w_waiting && !mem_ready)
                r_wait <= r_wait + WW'(1);
            if (w_next == S_FETCH && r_state != S_FETCH)
                r_instret <= r_instret + CNT_W'(1);
        end
    end

`ifdef MULDIV_EN
    logic r_md_fresh;
    logic r_md_wb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_md_fresh <= 1'b0;
            r_md_wb    <= 1'b0;
        end else begin
            r_md_fresh <= (w_next == S_MDWAIT) && (r_state != S_MDWAIT);
            r_md_wb    <= (r_state == S_MDWAIT);
        end
    end

    assign md_start = (r_state == S_MDWAIT) && r_md_fresh;
    assign w_md_wb  = r_md_wb;
`else
    logic w_unused;
    assign w_unused = ^{funct7_0, md_done};
    assign md_start = 1'b0;
    assign w_md_wb  = 1'b0;
`endif

    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_control = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = w_alu_dec;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = w_alu_dec;
            end
            S_ALUWB: begin
                result_src = w_md_wb ? 2'b11 : 2'b00;
                reg_write  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = zero ^ funct3[0];
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                reg_write = 1'b1;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    assign imm_src    = imm_sel(op);
    assign instret    = r_instret;
    assign trap       = (r_state == S_TRAP);
    assign trap_cause = r_cause;

endmodule
